boolean_expression_2: RTL and testbench

- Evaluates a fixed 4-input Boolean function Y = f(A,B,C,D) as a purely combinational output.
- Also provides a registered copy of Y and a saturating count of cycles in which Y was high, for use by downstream synchronous logic.
- Sits as a leaf block in the lab datapath. The combinational path must be exercisable with no clock running.

---
 rtl/boolean_expression_2_pkg.sv | 17 +
 rtl/boolean_expression_2_lut4.sv | 21 ++
 rtl/boolean_expression_2.sv | 61 ++++++
 tb/tb_boolean_expression_2.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/boolean_expression_2_pkg.sv
// Shared constants and helpers for the boolean_expression_2 block: the default
// minterm map, default counter width and the LUT index type.
package boolean_expression_2_pkg;

    // Minterms 3,4,5,7,8,9,10,11,15 -> Y = A&~B | C&D | ~A&B&~C
    localparam logic [15:0] DEFAULT_TRUTH_TABLE = 16'h8FB8;
    localparam int          DEFAULT_CNT_W       = 8;
    localparam int          LUT_ENTRIES         = 16;

    typedef logic [3:0] lut_idx_t;

    function automatic lut_idx_t pack_idx(input logic a, input logic b,
                                          input logic c, input logic d);
        return {a, b, c, d};
    endfunction

endpackage

// File: rtl/boolean_expression_2_lut4.sv
// bool_lut4: purely combinational 16-entry lookup; output follows the index
// with zero latency and no clock dependence.
module bool_lut4
    import boolean_expression_2_pkg::*;
#(
    parameter logic [15:0] TRUTH_TABLE = DEFAULT_TRUTH_TABLE
) (
    input  lut_idx_t idx,
    output logic     y
);

    logic [LUT_ENTRIES-1:0] table_bits;

    assign table_bits = TRUTH_TABLE;

    // An X/Z index is allowed to propagate straight through to y.
    always_comb begin
        y = table_bits[idx];
    end

endmodule

// File: rtl/boolean_expression_2.sv
// boolean_expression_2: fixed 4-input Boolean function with a registered copy
// of the result and a saturating count of clock edges on which it was high.
module boolean_expression_2
    import boolean_expression_2_pkg::*;
#(
    parameter logic [15:0] TRUTH_TABLE = DEFAULT_TRUTH_TABLE,
    parameter int          CNT_W       = DEFAULT_CNT_W
) (
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    output logic             Y,
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_clr,
    output logic             y_q,
    output logic [CNT_W-1:0] hi_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    lut_idx_t idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == CNT_MAX) begin
            return cnt;
        end
        return cnt + CNT_ONE;
    endfunction

    assign idx = pack_idx(A, B, C, D);

    bool_lut4 #(
        .TRUTH_TABLE(TRUTH_TABLE)
    ) u_lut (
        .idx(idx),
        .y  (Y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= 1'b0;
        end else begin
            y_q <= Y;
        end
    end

    // Clear takes priority over counting; at all-ones the counter holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_cnt <= '0;
        end else if (cnt_clr) begin
            hi_cnt <= '0;
        end else if (Y) begin
            hi_cnt <= sat_inc(hi_cnt);
        end
    end

endmodule

// File: tb/tb_boolean_expression_2.sv
// Bench for boolean_expression_2: truth-table sweep, directed register
// sequences, then randomized traffic against a behavioural model.
module tb_boolean_expression_2;

    localparam int CNT_W   = 8;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             A, B, C, D;
    logic             Y;
    logic             clk, rst, cnt_clr;
    logic             y_q;
    logic [CNT_W-1:0] hi_cnt;

    int nvec;
    int nfail;

    int exp_cnt;
    int exp_yq;

    typedef struct {
        logic [3:0] idx;
        logic       exp_y;
    } vec_t;

    vec_t tbl[16];

    boolean_expression_2 #(
        .TRUTH_TABLE(16'h8FB8),
        .CNT_W      (CNT_W)
    ) dut (
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D),
        .Y      (Y),
        .clk    (clk),
        .rst    (rst),
        .cnt_clr(cnt_clr),
        .y_q    (y_q),
        .hi_cnt (hi_cnt)
    );

    function automatic logic ref_y(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (a & ~b) | (c & d) | (~a & b & ~c);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] v);
        {A, B, C, D} = v;
    endtask

    // One full clock period; returns on the falling edge, away from the
    // active edge, with the model advanced to match.
    task automatic tick();
        int yv;
        yv = int'(ref_y({A, B, C, D}));
        #5 clk = 1'b1;
        if (cnt_clr) exp_cnt = 0;
        else if (yv == 1 && exp_cnt < CNT_SAT) exp_cnt++;
        exp_yq = yv;
        #5 clk = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_y_q"}, int'(y_q), exp_yq);
        check({tag, "_hi_cnt"}, int'(hi_cnt), exp_cnt);
    endtask

    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        #1;
        exp_cnt = 0;
        exp_yq  = 0;
        check_regs("async_rst");
        rst = 1'b0;
    endtask

    initial begin
        int exp_seq[16] = '{0,0,0,1,1,1,0,1,1,1,1,1,0,0,0,1};
        nvec    = 0;
        nfail   = 0;
        clk     = 1'b0;
        cnt_clr = 1'b0;
        exp_cnt = 0;
        exp_yq  = 0;
        set_in(4'b0000);

        for (int i = 0; i < 16; i++) begin
            tbl[i].idx   = 4'(i);
            tbl[i].exp_y = exp_seq[i][0];
        end

        rst = 1'b1;
        #1;
        check_regs("reset_state");
        rst = 1'b0;

        // Combinational sweep with no clock running.
        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].idx);
            #10;
            check($sformatf("sweep_Y_%04b", tbl[i].idx), int'(Y), int'(tbl[i].exp_y));
            check($sformatf("model_Y_%04b", tbl[i].idx), int'(ref_y(tbl[i].idx)), int'(tbl[i].exp_y));
        end

        // Reset held: Y live, registers pinned at zero even across an edge.
        rst = 1'b1;
        set_in(4'b1000);
        #1;
        check("rst_Y", int'(Y), 1);
        check_regs("rst_held");
        #5 clk = 1'b1;
        #5 clk = 1'b0;
        check_regs("rst_held_edge");
        rst = 1'b0;
        tick();
        check("rel_y_q", int'(y_q), 1);
        check("rel_hi_cnt", int'(hi_cnt), 1);

        // 5 high edges then 3 low edges.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        set_in(4'b0011);
        repeat (5) tick();
        set_in(4'b1100);
        repeat (3) tick();
        check("seq53_hi_cnt", int'(hi_cnt), 5);
        check("seq53_y_q", int'(y_q), 0);

        // Saturation.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        set_in(4'b1111);
        for (int i = 1; i <= 260; i++) begin
            tick();
            if (i == 254) check("sat_254", int'(hi_cnt), 254);
            if (i == 255) check("sat_255", int'(hi_cnt), 255);
        end
        check("sat_hold", int'(hi_cnt), 255);
        check_regs("sat_model");

        // Clear beats increment.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        set_in(4'b0100);
        repeat (10) tick();
        check("pre_clr", int'(hi_cnt), 10);
        cnt_clr = 1'b1;
        tick();
        check("clr_wins", int'(hi_cnt), 0);
        cnt_clr = 1'b0;
        tick();
        check("after_clr", int'(hi_cnt), 1);

        // Asynchronous reset between edges.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        set_in(4'b1001);
        repeat (7) tick();
        check("pre_arst", int'(hi_cnt), 7);
        check("pre_arst_y_q", int'(y_q), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_hi_cnt", int'(hi_cnt), 0);
        check("arst_y_q", int'(y_q), 0);
        check("arst_Y", int'(Y), 1);
        rst = 1'b0;
        exp_cnt = 0;
        exp_yq  = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_in(4'($urandom_range(15, 0)));
            cnt_clr = ($urandom_range(15, 0) == 0);
            #1;
            check("rand_Y", int'(Y), int'(ref_y({A, B, C, D})));
            #0;
            tick();
            check_regs("rand");
            if ($urandom_range(49, 0) == 0) async_reset_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
